rsa_job_arbiter: RTL and testbench
==================================

RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter TMO_W, default 16, width of the timeout counter and limit.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ena  in  1  design enable; low freezes all state.
REQ-006 req  in  2  level request per requester, [0]=SPI, [1]=GPIO.
REQ-007 abort  in  2  per-requester abort, honoured only from the current owner.
REQ-008 op_p, op_e, op_m, op_const  in  WIDTH each  shared operand bus, sampled at grant.
REQ-009 tmo_limit  in  TMO_W  max RUN cycles; 0 disables timeout.
REQ-010 irq_clr  in  1  clears irq and err_flag.
REQ-011 rsa_eoc, rsa_c  in  1 / WIDTH  end-of-computation and result from the RSA unit.
REQ-012 rsa_en, rsa_clr  out  1 each  RSA unit enable and active-high clear (inverted externally to the unit's reset).
REQ-013 rsa_p, rsa_e, rsa_m, rsa_const  out  WIDTH each  registered operands for the unit.
REQ-014 gnt  out  2  one-hot owner, held LOAD through DONE.
REQ-015 done  out  2  one-cycle completion pulse to the owner.
REQ-016 result, result_vld  out  WIDTH / 1  captured C and its valid flag.
REQ-017 busy, irq, err_flag  out  1 each  non-IDLE, sticky completion interrupt, sticky timeout flag.

Function
REQ-018 FSM states: IDLE, LOAD, RUN, DONE, ERR.
REQ-019 IDLE: any req bit high -> LOAD next cycle; selected gnt bit set on the same edge.
REQ-020 Arbitration is round-robin: on simultaneous requests, the requester not granted last wins; after reset SPI wins.
REQ-021 LOAD lasts one cycle: operands captured into rsa_* registers, rsa_clr=1, rsa_en=0, result_vld cleared, timeout counter cleared -> RUN.
REQ-022 RUN: rsa_en=1, rsa_clr=0, counter increments each cycle.
REQ-023 RUN: rsa_eoc=1 -> DONE; result<=rsa_c, result_vld<=1 on the same edge.
REQ-024 DONE lasts one cycle: done[owner]=1, rsa_en=0, irq set -> IDLE, gnt cleared.
REQ-025 RUN with tmo_limit!=0 and counter==tmo_limit-1 and no rsa_eoc -> ERR; if rsa_eoc arrives the same cycle, eoc wins.
REQ-026 ERR lasts one cycle: rsa_clr=1, err_flag set, done[owner]=1, result_vld stays 0 -> IDLE.
REQ-027 abort[owner]=1 in LOAD or RUN -> IDLE next cycle with rsa_clr=1 that cycle; no done, no irq; abort from a non-owner is ignored.
REQ-028 Latency: req sampled high at edge N gives gnt at N+1, rsa_en first high at N+2, done one cycle after the rsa_eoc edge.
REQ-029 irq_clr and an irq/err set in the same cycle: the set wins.
REQ-030 ena=0: state, counters and outputs hold, except rsa_en is forced 0; a pending eoc is not lost because the unit is also frozen.
REQ-031 Requests in LOAD, RUN, DONE or ERR are not queued; a level still high in IDLE is re-arbitrated.
REQ-032 busy=1 in every state except IDLE.

Reset
REQ-033 rst=1: state=IDLE, gnt=0, done=0, rsa_en=0, rsa_clr=1, rsa_* operands=0, result=0, result_vld=0, irq=0, err_flag=0, counter=0, round-robin pointer selects SPI.
REQ-034 rst during RUN aborts the job silently; rsa_clr=1 the following cycle.

Structure
REQ-035 FSM state encoding and the requester index constants (REQ_SPI=0, REQ_GPIO=1) live in a shared package, rsa_pkg.
REQ-036 One sub-module, rsa_rr_arb2: a two-input round-robin arbiter with a last-grant pointer.

Verification
REQ-037 Single SPI request; P=61, E=17, M=5, unit asserts eoc after 20 RUN cycles with C=0x2A -> gnt=01, result=0x2A, done[0] pulse, irq=1.
REQ-038 req=11 on consecutive jobs -> grants alternate 01, 10, 01.
REQ-039 tmo_limit=4 with eoc never asserted -> ERR after 4 RUN cycles, err_flag=1, done pulse, result_vld=0.
REQ-040 abort[1] from GPIO while SPI owns the unit -> ignored; abort[0] -> IDLE, rsa_clr pulse, no irq.
REQ-041 irq_clr asserted in the DONE cycle -> irq=1 after the edge; irq_clr the next cycle -> irq=0.
REQ-042 ena=0 for 3 cycles mid-RUN -> rsa_en=0, counter holds, job completes correctly after ena returns high.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job arbiter.
// Contents: FSM state encoding, requester index constants.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam int unsigned REQ_SPI  = 0;
    localparam int unsigned REQ_GPIO = 1;
    localparam int unsigned NUM_REQ  = 2;

endpackage

// File: rtl/rsa_job_arbiter_if.sv
// Bundle of all job-arbiter signals except clock and reset.
// Ports (slave = arbiter view):
//   in : ena, req[1:0], abort[1:0], op_p/op_e/op_m/op_const, tmo_limit,
//        irq_clr, rsa_eoc, rsa_c
//   out: rsa_en, rsa_clr, rsa_p/rsa_e/rsa_m/rsa_const, gnt[1:0], done[1:0],
//        result, result_vld, busy, irq, err_flag
// The master modport is the mirror image (requesters plus the RSA unit).
interface rsa_job_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int TMO_W = 16
);
    logic             ena;
    logic [1:0]       req;
    logic [1:0]       abort;
    logic [WIDTH-1:0] op_p;
    logic [WIDTH-1:0] op_e;
    logic [WIDTH-1:0] op_m;
    logic [WIDTH-1:0] op_const;
    logic [TMO_W-1:0] tmo_limit;
    logic             irq_clr;
    logic             rsa_eoc;
    logic [WIDTH-1:0] rsa_c;

    logic             rsa_en;
    logic             rsa_clr;
    logic [WIDTH-1:0] rsa_p;
    logic [WIDTH-1:0] rsa_e;
    logic [WIDTH-1:0] rsa_m;
    logic [WIDTH-1:0] rsa_const;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] result;
    logic             result_vld;
    logic             busy;
    logic             irq;
    logic             err_flag;

    modport slave (
        input  ena, req, abort, op_p, op_e, op_m, op_const, tmo_limit,
               irq_clr, rsa_eoc, rsa_c,
        output rsa_en, rsa_clr, rsa_p, rsa_e, rsa_m, rsa_const, gnt, done,
               result, result_vld, busy, irq, err_flag
    );

    modport master (
        output ena, req, abort, op_p, op_e, op_m, op_const, tmo_limit,
               irq_clr, rsa_eoc, rsa_c,
        input  rsa_en, rsa_clr, rsa_p, rsa_e, rsa_m, rsa_const, gnt, done,
               result, result_vld, busy, irq, err_flag
    );

endinterface

// File: rtl/rsa_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ena      : freezes the pointer when low
//   req[1:0] : request levels, [0]=SPI, [1]=GPIO
//   take     : the current grant is being accepted this cycle
//   gnt[1:0] : combinational one-hot grant (zero when no request)
module rsa_rr_arb2
    import rsa_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    // High when GPIO was granted last; resets high so SPI wins first.
    logic last_gpio;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gpio <= 1'b1;
        end else if (ena && take) begin
            last_gpio <= gnt[REQ_GPIO];
        end
    end

    always_comb begin
        gnt = '0;
        if (req[REQ_SPI] && req[REQ_GPIO]) begin
            if (last_gpio) begin
                gnt[REQ_SPI] = 1'b1;
            end else begin
                gnt[REQ_GPIO] = 1'b1;
            end
        end else if (req[REQ_SPI]) begin
            gnt[REQ_SPI] = 1'b1;
        end else if (req[REQ_GPIO]) begin
            gnt[REQ_GPIO] = 1'b1;
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Arbitrates a shared RSA unit between an SPI and a GPIO requester,
// sequences one job (load, run, done/timeout/abort) and reports results.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : rsa_job_arbiter_if.slave (requests, operands, unit
//              handshake, grant/done, result, status flags)
module rsa_job_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TMO_W = 16
) (
    input logic              clk,
    input logic              rst,
    rsa_job_arbiter_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       gnt_q;
    logic [1:0]       arb_gnt;
    logic [TMO_W-1:0] cnt_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] k_q;
    logic [WIDTH-1:0] result_q;
    logic             vld_q;
    logic             clr_q;
    logic             irq_q;
    logic             err_q;
    logic             abort_hit;
    logic             tmo_hit;
    logic             take;
    logic             job_dropped;

    assign abort_hit = |(bus.abort & gnt_q);
    assign tmo_hit   = (bus.tmo_limit != '0) &&
                       (cnt_q == bus.tmo_limit - TMO_W'(1));
    assign take      = (state_q == ST_IDLE) && (|bus.req);
    // Abort or nothing else: leaving LOAD/RUN straight back to IDLE.
    assign job_dropped = ((state_q == ST_LOAD) || (state_q == ST_RUN)) &&
                         (state_d == ST_IDLE);

    rsa_rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .ena  (bus.ena),
        .req  (bus.req),
        .take (take),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|bus.req) state_d = ST_LOAD;
            ST_LOAD: state_d = abort_hit ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                // Abort beats eoc; eoc beats a same-cycle timeout.
                if (abort_hit) begin
                    state_d = ST_IDLE;
                end else if (bus.rsa_eoc) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            vld_q    <= 1'b0;
            clr_q    <= 1'b1;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (bus.ena) begin
            state_q <= state_d;
            // Registered clear: high through LOAD, ERR and the cycle after an abort.
            clr_q   <= (state_d == ST_LOAD) || (state_d == ST_ERR) || job_dropped;

            if (take) begin
                gnt_q <= arb_gnt;
                p_q   <= bus.op_p;
                e_q   <= bus.op_e;
                m_q   <= bus.op_m;
                k_q   <= bus.op_const;
                vld_q <= 1'b0;
                cnt_q <= '0;
            end else if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
                gnt_q <= '0;
            end

            if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + TMO_W'(1);
                if (state_d == ST_DONE) begin
                    result_q <= bus.rsa_c;
                    vld_q    <= 1'b1;
                end
            end

            // Set takes priority over a same-cycle clear.
            if (state_q == ST_DONE) begin
                irq_q <= 1'b1;
            end else if (bus.irq_clr) begin
                irq_q <= 1'b0;
            end

            if (state_q == ST_ERR) begin
                err_q <= 1'b1;
            end else if (bus.irq_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = ((state_q == ST_DONE) || (state_q == ST_ERR)) ? gnt_q : '0;
    assign bus.rsa_en     = (state_q == ST_RUN) && bus.ena;
    assign bus.rsa_clr    = clr_q;
    assign bus.rsa_p      = p_q;
    assign bus.rsa_e      = e_q;
    assign bus.rsa_m      = m_q;
    assign bus.rsa_const  = k_q;
    assign bus.result     = result_q;
    assign bus.result_vld = vld_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.irq        = irq_q;
    assign bus.err_flag   = err_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Self-checking bench for rsa_job_arbiter: directed scenarios plus random
// jobs, a behavioural RSA-unit stand-in and a scoreboard monitor on done.
module tb_rsa_job_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rsa_job_arbiter_if #(.WIDTH(8), .TMO_W(16)) bus ();

    rsa_job_arbiter #(.WIDTH(8), .TMO_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic [7:0]  c;
        logic [7:0]  p;
        logic [7:0]  e;
        logic [7:0]  m;
        logic [7:0]  k;
        bit          err;
        int unsigned run;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned unit_delay = 0;
    int unsigned unit_cnt = 0;
    int unsigned run_cnt = 0;
    int unsigned last_owner = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RSA unit stand-in: counts enabled cycles, raises eoc on the chosen one,
    // holds everything while disabled, clears on rsa_clr.
    initial begin
        bus.rsa_eoc = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsa_clr) begin
                unit_cnt    = 0;
                bus.rsa_eoc = 1'b0;
            end else if (bus.rsa_en) begin
                unit_cnt++;
                bus.rsa_eoc = (unit_delay != 0) && (unit_cnt == unit_delay);
            end
        end
    end

    // Scoreboard monitor: every completion pulse pops one expected job.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                run_cnt = 0;
            end else if (bus.ena) begin
                if (bus.rsa_clr && bus.busy && (bus.done == 2'b00)) run_cnt = 0;
                if (bus.rsa_en) run_cnt++;
                if (bus.done != 2'b00) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=%0h required=0", bus.done);
                    end else begin
                        mon_e = sb.pop_front();
                        check("done_owner", bus.done, mon_e.gnt);
                        check("result_vld", bus.result_vld, !mon_e.err);
                        if (!mon_e.err) check("result", bus.result, mon_e.c);
                        check("run_cycles", run_cnt, mon_e.run);
                        check("rsa_p_held", bus.rsa_p, mon_e.p);
                        check("rsa_e_held", bus.rsa_e, mon_e.e);
                        check("rsa_m_held", bus.rsa_m, mon_e.m);
                        check("rsa_const_held", bus.rsa_const, mon_e.k);
                        run_cnt = 0;
                    end
                end
            end
        end
    end

    // Issues a request, checks the LOAD cycle and first RUN cycle, and
    // returns with the job running.
    task automatic start_job(input logic [1:0] pat, input int unsigned d, input int unsigned lim,
                             input logic [7:0] c, input logic [7:0] p, input logic [7:0] e,
                             input logic [7:0] m, input logic [7:0] k, input bit push,
                             output bit err_o);
        exp_t       x;
        logic [1:0] og;
        if (pat == 2'b11) og = (last_owner == 1) ? 2'b01 : 2'b10;
        else              og = pat;
        last_owner = (og == 2'b10) ? 1 : 0;
        x.gnt = og;
        x.c   = c;
        x.p   = p;
        x.e   = e;
        x.m   = m;
        x.k   = k;
        x.err = (lim != 0) && ((d == 0) || (d > lim));
        x.run = x.err ? lim : d;
        err_o = x.err;
        if (push) sb.push_back(x);

        bus.op_p      = p;
        bus.op_e      = e;
        bus.op_m      = m;
        bus.op_const  = k;
        bus.tmo_limit = 16'(lim);
        bus.rsa_c     = c;
        unit_delay    = d;
        bus.req       = pat;
        tick();
        bus.req = 2'b00;
        check("gnt_load", bus.gnt, og);
        check("busy_load", bus.busy, 1);
        check("rsa_clr_load", bus.rsa_clr, 1);
        check("rsa_en_load", bus.rsa_en, 0);
        check("result_vld_load", bus.result_vld, 0);
        check("rsa_p_load", bus.rsa_p, p);
        check("rsa_e_load", bus.rsa_e, e);
        check("rsa_m_load", bus.rsa_m, m);
        check("rsa_const_load", bus.rsa_const, k);
        bus.op_p     = 8'($urandom);
        bus.op_e     = 8'($urandom);
        bus.op_m     = 8'($urandom);
        bus.op_const = 8'($urandom);
        tick();
        check("rsa_en_run", bus.rsa_en, 1);
        check("rsa_clr_run", bus.rsa_clr, 0);
        check("gnt_run", bus.gnt, og);
    endtask

    task automatic finish_job(input bit err_exp, input bit stall);
        int unsigned n;
        n = 0;
        while (bus.busy && (n < 400)) begin
            bus.ena = (stall && ($urandom_range(0, 4) == 0)) ? 1'b0 : 1'b1;
            tick();
            n++;
        end
        bus.ena = 1'b1;
        check("job_completes", bus.busy, 0);
        check("gnt_cleared", bus.gnt, 0);
        if (err_exp) begin
            check("err_flag_set", bus.err_flag, 1);
            check("irq_not_set_on_err", bus.irq, 0);
        end else begin
            check("irq_set", bus.irq, 1);
            check("err_not_set_on_done", bus.err_flag, 0);
        end
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        check("irq_cleared", bus.irq, 0);
        check("err_cleared", bus.err_flag, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          e;
        int unsigned n;
        logic [1:0]  pat;
        int unsigned d;
        int unsigned lim;

        bus.ena       = 1'b1;
        bus.req       = 2'b00;
        bus.abort     = 2'b00;
        bus.op_p      = '0;
        bus.op_e      = '0;
        bus.op_m      = '0;
        bus.op_const  = '0;
        bus.tmo_limit = '0;
        bus.irq_clr   = 1'b0;
        bus.rsa_c     = '0;

        tick();
        tick();
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_rsa_en", bus.rsa_en, 0);
        check("rst_rsa_clr", bus.rsa_clr, 1);
        check("rst_rsa_p", bus.rsa_p, 0);
        check("rst_rsa_e", bus.rsa_e, 0);
        check("rst_result", bus.result, 0);
        check("rst_result_vld", bus.result_vld, 0);
        check("rst_irq", bus.irq, 0);
        check("rst_err", bus.err_flag, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();

        // Single SPI job, eoc after 20 RUN cycles.
        start_job(2'b01, 20, 0, 8'h2A, 8'd61, 8'd17, 8'd5, 8'd3, 1, e);
        finish_job(e, 0);
        check("result_after_spi", bus.result, 8'h2A);
        check("result_vld_after_spi", bus.result_vld, 1);

        // Simultaneous requests alternate.
        start_job(2'b11, 2, 0, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 1, e);
        finish_job(e, 0);
        start_job(2'b11, 3, 0, 8'h20, 8'h05, 8'h06, 8'h07, 8'h08, 1, e);
        finish_job(e, 0);
        start_job(2'b11, 1, 0, 8'h30, 8'h09, 8'h0A, 8'h0B, 8'h0C, 1, e);
        finish_job(e, 0);

        // Timeout with eoc never raised.
        start_job(2'b10, 0, 4, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 1, e);
        finish_job(e, 0);
        check("result_vld_after_err", bus.result_vld, 0);

        // eoc in the last allowed cycle beats the timeout.
        start_job(2'b10, 5, 5, 8'h77, 8'h12, 8'h34, 8'h56, 8'h78, 1, e);
        finish_job(e, 0);

        // Abort: non-owner ignored, owner drops the job.
        start_job(2'b01, 0, 0, 8'h99, 8'h01, 8'h01, 8'h01, 8'h01, 0, e);
        tick();
        bus.abort = 2'b10;
        tick();
        bus.abort = 2'b00;
        check("abort_nonowner_busy", bus.busy, 1);
        check("abort_nonowner_gnt", bus.gnt, 2'b01);
        bus.abort = 2'b01;
        tick();
        bus.abort = 2'b00;
        check("abort_idle", bus.busy, 0);
        check("abort_gnt", bus.gnt, 0);
        check("abort_rsa_clr", bus.rsa_clr, 1);
        check("abort_done", bus.done, 0);
        tick();
        check("abort_rsa_clr_pulse_end", bus.rsa_clr, 0);
        check("abort_no_irq", bus.irq, 0);

        // irq_clr in the DONE cycle loses to the set.
        start_job(2'b10, 3, 0, 8'hC3, 8'h21, 8'h22, 8'h23, 8'h24, 1, e);
        n = 0;
        while ((bus.done == 2'b00) && (n < 50)) begin
            tick();
            n++;
        end
        check("done_seen", bus.done, 2'b10);
        bus.irq_clr = 1'b1;
        tick();
        check("irq_set_wins", bus.irq, 1);
        tick();
        bus.irq_clr = 1'b0;
        check("irq_cleared_next", bus.irq, 0);

        // Freeze mid-RUN; the timeout would fire if the counter kept running.
        start_job(2'b01, 20, 22, 8'hE1, 8'h31, 8'h32, 8'h33, 8'h34, 1, e);
        repeat (5) tick();
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frozen_rsa_en", bus.rsa_en, 0);
            check("frozen_busy", bus.busy, 1);
        end
        bus.ena = 1'b1;
        finish_job(e, 0);
        check("result_after_freeze", bus.result, 8'hE1);

        // Reset in RUN drops the job silently and restores SPI priority.
        start_job(2'b10, 0, 0, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 0, e);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_owner = 1;
        check("rst_run_busy", bus.busy, 0);
        check("rst_run_gnt", bus.gnt, 0);
        check("rst_run_clr", bus.rsa_clr, 1);
        tick();
        start_job(2'b11, 2, 0, 8'h5A, 8'h51, 8'h52, 8'h53, 8'h54, 1, e);
        finish_job(e, 0);

        // Random jobs with random enable stalls.
        for (int i = 0; i < 40; i++) begin
            pat = 2'($urandom_range(1, 3));
            d   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
            lim = $urandom_range(0, 12);
            if ((d == 0) && (lim == 0)) lim = $urandom_range(1, 12);
            start_job(pat, d, lim, 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), 1, e);
            finish_job(e, 1);
        end

        tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
